rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer_if.sv | 31 +++
 rtl/rst_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_rst_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: bundles the reset-request inputs and the staged reset
// outputs of rst_sequencer. The master side drives the requests, and the
// slave side (the sequencer) drives the reset vector and status.
interface rst_sequencer_if #(
  parameter int NumDomains = 3
);
  logic                  pll_locked_i;
  logic                  rst_btn_i;
  logic                  sw_rst_req_i;
  logic [NumDomains-1:0] rst_no;
  logic                  rst_done_o;
  logic [1:0]            rst_cause_o;

  modport master (
    output pll_locked_i,
    output rst_btn_i,
    output sw_rst_req_i,
    input  rst_no,
    input  rst_done_o,
    input  rst_cause_o
  );

  modport slave (
    input  pll_locked_i,
    input  rst_btn_i,
    input  sw_rst_req_i,
    output rst_no,
    output rst_done_o,
    output rst_cause_o
  );
endinterface

// File: rtl/rst_sequencer.sv
// rst_sequencer: staged reset release for NumDomains reset domains.
// After power-on, and after any later reset request, every domain is held in
// reset. Once the hold period ends, domains are released one at a time in
// ascending bit order, StageDelay cycles apart.
// Any of the following sends every domain back into reset on a single edge:
//   - loss of PLL lock (synchronised)
//   - a debounced button press
//   - a software request
// The cause of the most recent reset is recorded in rst_cause_o.
// Parameters must all be >= 1.
module rst_sequencer #(
  parameter int NumDomains     = 3,
  parameter int StageDelay     = 16,
  parameter int DebounceCycles = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rst_sequencer_if.slave bus
);

  localparam int CntW = $clog2(StageDelay + 1);
  localparam int DbW  = $clog2(DebounceCycles + 1);
  localparam int IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  localparam logic [CntW-1:0]       CntLast  = CntW'(StageDelay - 1);
  localparam logic [DbW-1:0]        DbMax    = DbW'(DebounceCycles);
  localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NumDomains - 1);
  localparam logic [NumDomains-1:0] DomFirst = NumDomains'(1);

  localparam logic [1:0] CausePor = 2'b00;
  localparam logic [1:0] CausePll = 2'b01;
  localparam logic [1:0] CauseBtn = 2'b10;
  localparam logic [1:0] CauseSw  = 2'b11;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_e;

  logic lock_meta_q, lock_s_q;
  logic btn_meta_q, btn_s_q;

  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           btn_db;

  logic trig_pll, trig_btn, trig_sw, trig_any;
  logic [1:0] cause_sel;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumDomains-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic [1:0]            cause_q, cause_d;

  // Two-flop synchronisers for the asynchronous lock and button inputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_s_q     <= 1'b0;
    end else begin
      lock_meta_q <= bus.pll_locked_i;
      lock_s_q    <= lock_meta_q;
      btn_meta_q  <= bus.rst_btn_i;
      btn_s_q     <= btn_meta_q;
    end
  end

  // Debounce: count consecutive high samples, saturate at the threshold, clear on any low
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (!btn_s_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DbMax) begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  // Debounce counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end

  assign btn_db   = (db_cnt_q == DbMax);
  assign trig_pll = ~lock_s_q;
  assign trig_btn = btn_db;
  assign trig_sw  = bus.sw_rst_req_i;
  assign trig_any = trig_pll | trig_btn | trig_sw;

  // Highest-priority active trigger, recorded as the cause on reassertion
  always_comb begin
    cause_sel = CauseSw;
    if (trig_pll) begin
      cause_sel = CausePll;
    end else if (trig_btn) begin
      cause_sel = CauseBtn;
    end
  end

  // Sequencer next state: hold period, staged release, and reassertion on any trigger
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    cause_d = cause_q;
    unique case (state_q)
      HOLD: begin
        rst_n_d = '0;
        done_d  = 1'b0;
        if (trig_pll || trig_btn) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          rst_n_d = DomFirst;
          cnt_d   = '0;
          idx_d   = '0;
          if (NumDomains == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RELEASE: begin
        if (trig_any) begin
          state_d = HOLD;
          rst_n_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          cause_d = cause_sel;
        end else if (cnt_q == CntLast) begin
          rst_n_d = (rst_n_q << 1) | DomFirst;
          idx_d   = idx_q + IdxW'(1);
          cnt_d   = '0;
          if ((idx_q + IdxW'(1)) == IdxLast) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RUN: begin
        if (trig_any) begin
          state_d = HOLD;
          rst_n_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          cause_d = cause_sel;
        end
      end
      default: begin
        state_d = HOLD;
        rst_n_d = '0;
        done_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Sequencer registers; reset outputs come straight from these flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= CausePor;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign bus.rst_no      = rst_n_q;
  assign bus.rst_done_o  = done_q;
  assign bus.rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed, table-driven bench for rst_sequencer.
// The main instance uses the default parameters. A second instance uses
// NumDomains=1, StageDelay=1 and covers the minimal configuration.
// Each table row applies inputs for a number of cycles, then checks the
// outputs against hand-computed values.
module tb_rst_sequencer;

  typedef struct packed {
    int unsigned cycles;
    logic        pll;
    logic        btn;
    logic        sw;
    logic [2:0]  expN;
    logic        expDone;
    logic [1:0]  expCause;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  rst_sequencer_if #(.NumDomains(3)) bus ();
  rst_sequencer_if #(.NumDomains(1)) bus2 ();

  rst_sequencer #(
    .NumDomains(3),
    .StageDelay(16),
    .DebounceCycles(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  rst_sequencer #(
    .NumDomains(1),
    .StageDelay(1),
    .DebounceCycles(4)
  ) dutSweep (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus2)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stalled run
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic stepCycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pll, input logic btn, input logic sw,
                               input int unsigned n);
    bus.pll_locked_i = pll;
    bus.rst_btn_i    = btn;
    bus.sw_rst_req_i = sw;
    stepCycles(n);
  endtask

  task automatic checkOutput(input string name,
                             input logic [2:0] gotN, input logic gotDone,
                             input logic [1:0] gotCause,
                             input logic [2:0] expN, input logic expDone,
                             input logic [1:0] expCause);
    checks++;
    if (gotN !== expN) begin
      errors++;
      $display("[TB] FAIL %s rst_no got %b expected %b", name, gotN, expN);
    end
    checks++;
    if (gotDone !== expDone) begin
      errors++;
      $display("[TB] FAIL %s rst_done_o got %b expected %b", name, gotDone, expDone);
    end
    checks++;
    if (gotCause !== expCause) begin
      errors++;
      $display("[TB] FAIL %s rst_cause_o got %b expected %b", name, gotCause, expCause);
    end
  endtask

  function automatic void addVec(input int unsigned c, input logic p, input logic b,
                                 input logic s, input logic [2:0] n, input logic d,
                                 input logic [1:0] ca);
    vec_t v;
    v.cycles   = c;
    v.pll      = p;
    v.btn      = b;
    v.sw       = s;
    v.expN     = n;
    v.expDone  = d;
    v.expCause = ca;
    vecs.push_back(v);
  endfunction

  initial begin
    // Edge numbers in comments count from the first edge after rst falls.
    //     cycles pll btn sw  rst_no  done cause
    addVec(14, 1, 0, 0, 3'b000, 0, 2'b00);  // edge 17: hold not yet over
    addVec( 1, 1, 0, 0, 3'b001, 0, 2'b00);  // 18: domain 0 released
    addVec(15, 1, 0, 0, 3'b001, 0, 2'b00);  // 33
    addVec( 1, 1, 0, 0, 3'b011, 0, 2'b00);  // 34: domain 1
    addVec(15, 1, 0, 0, 3'b011, 0, 2'b00);  // 49
    addVec( 1, 1, 0, 0, 3'b111, 1, 2'b00);  // 50: all released
    addVec( 3, 1, 1, 0, 3'b111, 1, 2'b00);  // 53: 3-cycle press
    addVec( 6, 1, 0, 0, 3'b111, 1, 2'b00);  // 59: short press ignored
    addVec( 6, 1, 1, 0, 3'b111, 1, 2'b00);  // 65: 6th edge of long press
    addVec( 1, 1, 1, 0, 3'b000, 0, 2'b10);  // 66: 7th edge -> reset
    addVec( 3, 1, 1, 0, 3'b000, 0, 2'b10);  // 69: 10 cycles held
    addVec(18, 1, 0, 0, 3'b000, 0, 2'b10);  // 87: hold restarted at 72
    addVec( 1, 1, 0, 0, 3'b001, 0, 2'b10);  // 88
    addVec( 2, 0, 0, 0, 3'b001, 0, 2'b10);  // 90: lock loss in sync
    addVec( 1, 0, 0, 0, 3'b000, 0, 2'b01);  // 91: 3rd edge -> reset
    addVec( 5, 0, 0, 0, 3'b000, 0, 2'b01);  // 96
    addVec(17, 1, 0, 0, 3'b000, 0, 2'b01);  // 113
    addVec( 1, 1, 0, 0, 3'b001, 0, 2'b01);  // 114
    addVec(32, 1, 0, 0, 3'b111, 1, 2'b01);  // 146
    addVec( 1, 1, 0, 1, 3'b000, 0, 2'b11);  // 147: software pulse
    addVec(47, 1, 0, 0, 3'b011, 0, 2'b11);  // 194
    addVec( 1, 1, 0, 0, 3'b111, 1, 2'b11);  // 195: 48 cycles after
    addVec( 1, 1, 0, 1, 3'b000, 0, 2'b11);  // 196: sw held from here
    addVec(15, 1, 0, 1, 3'b000, 0, 2'b11);  // 211: HOLD ignores sw
    addVec( 1, 1, 0, 1, 3'b001, 0, 2'b11);  // 212: released anyway
    addVec( 1, 1, 0, 1, 3'b000, 0, 2'b11);  // 213: sw re-enters HOLD
    addVec(48, 1, 0, 0, 3'b111, 1, 2'b11);  // 261
    addVec( 4, 1, 1, 0, 3'b111, 1, 2'b11);  // 265: button rising
    addVec( 2, 0, 1, 0, 3'b111, 1, 2'b11);  // 267: lock dropping
    addVec( 1, 0, 1, 1, 3'b000, 0, 2'b01);  // 268: all three -> pll
    addVec(18, 1, 0, 0, 3'b000, 0, 2'b01);  // 286
    addVec( 1, 1, 0, 0, 3'b001, 0, 2'b01);  // 287

    rst               = 1'b1;
    bus.pll_locked_i  = 1'b1;
    bus.rst_btn_i     = 1'b0;
    bus.sw_rst_req_i  = 1'b0;
    bus2.pll_locked_i = 1'b1;
    bus2.rst_btn_i    = 1'b0;
    bus2.sw_rst_req_i = 1'b0;

    stepCycles(3);
    checkOutput("reset", bus.rst_no, bus.rst_done_o, bus.rst_cause_o,
                3'b000, 1'b0, 2'b00);
    checkOutput("resetSweep", {2'b00, bus2.rst_no}, bus2.rst_done_o, bus2.rst_cause_o,
                3'b000, 1'b0, 2'b00);

    rst = 1'b0;
    stepCycles(2);
    checkOutput("sweepEdge2", {2'b00, bus2.rst_no}, bus2.rst_done_o, bus2.rst_cause_o,
                3'b000, 1'b0, 2'b00);
    stepCycles(1);
    checkOutput("sweepEdge3", {2'b00, bus2.rst_no}, bus2.rst_done_o, bus2.rst_cause_o,
                3'b001, 1'b1, 2'b00);
    checkOutput("powerEdge3", bus.rst_no, bus.rst_done_o, bus.rst_cause_o,
                3'b000, 1'b0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].pll, vecs[i].btn, vecs[i].sw, vecs[i].cycles);
      checkOutput($sformatf("row%0d", i), bus.rst_no, bus.rst_done_o, bus.rst_cause_o,
                  vecs[i].expN, vecs[i].expDone, vecs[i].expCause);
    end

    // Asynchronous reset in the middle of RELEASE, between clock edges
    stepCycles(5);
    checkOutput("preAsync", bus.rst_no, bus.rst_done_o, bus.rst_cause_o,
                3'b001, 1'b0, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncReset", bus.rst_no, bus.rst_done_o, bus.rst_cause_o,
                3'b000, 1'b0, 2'b00);
    checkOutput("asyncSweep", {2'b00, bus2.rst_no}, bus2.rst_done_o, bus2.rst_cause_o,
                3'b000, 1'b0, 2'b00);
    stepCycles(2);
    rst = 1'b0;

    // Sequencing restarts from HOLD after the reset is released
    stepCycles(17);
    checkOutput("restartEdge17", bus.rst_no, bus.rst_done_o, bus.rst_cause_o,
                3'b000, 1'b0, 2'b00);
    stepCycles(1);
    checkOutput("restartEdge18", bus.rst_no, bus.rst_done_o, bus.rst_cause_o,
                3'b001, 1'b0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
